// File: rtl/rb_word_packer.sv
// rb_word_packer
// Drain stage for the byte ring buffer. Pops one byte at a time from the
// buffer, packs PACK_BYTES consecutive bytes into a word (lane 0 = first
// byte, least significant) and offers the word on a valid/ready stream.
//
// Build option: define PACKER_TIMEOUT_EN to flush a partially filled word
// after TIMEOUT_CYCLES idle cycles. In this case out_keep marks only the
// filled lanes. Without the macro a partial word is held until it completes,
// and every emitted word has out_keep all ones.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous, active-high reset
//   rb_empty   in   upstream empty flag (registered, lags occupancy by one cycle)
//   rb_data    in   upstream read data, valid the cycle after an accepted rb_rd_en
//   rb_rd_en   out  upstream read strobe, one cycle per byte
//   out_data   out  packed word
//   out_keep   out  per-lane valid mask
//   out_valid  out  word available
//   out_ready  in   downstream ready
//   words_sent out  accepted word count, saturating
//
// Handshake: a word transfers on any rising edge where out_valid && out_ready.
// Once out_valid rises, it stays high and out_data/out_keep stay frozen
// until that transfer. out_valid is a register with no path from out_ready.
//
// The FSM state is the enum register 'state' (S_IDLE/S_RD/S_CAP/S_OUT).
// Bind checkers to it by hierarchical reference.

module rb_word_packer #(
  parameter int DATA_WIDTH     = 8,
  parameter int PACK_BYTES     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             rb_empty,
  input  logic [DATA_WIDTH-1:0]            rb_data,
  output logic                             rb_rd_en,
  output logic [DATA_WIDTH*PACK_BYTES-1:0] out_data,
  output logic [PACK_BYTES-1:0]            out_keep,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [15:0]                      words_sent
);

  localparam int LANE_W = $clog2(PACK_BYTES);
  localparam int OUT_W  = DATA_WIDTH * PACK_BYTES;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PACK_BYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_CAP  = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t              state;
  logic [LANE_W-1:0]   lane;
  logic [OUT_W-1:0]    data_q;
  logic [PACK_BYTES-1:0] keep_q;

  // Reads happen only from S_RD. The RD->CAP->IDLE cycle gives two cycles
  // between pulses. This lets the lagging rb_empty settle before S_IDLE
  // samples it again.
  assign rb_rd_en = (state == S_RD);
  assign out_data = data_q;
  assign out_keep = keep_q;

`ifdef PACKER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] idle_cnt;
  logic             timeout_hit;

  assign timeout_hit = (idle_cnt == CNT_W'(TIMEOUT_CYCLES));

  // The counter runs only while a partial word waits on an empty buffer.
  // It clears on a read, and it clears once the FSM leaves S_IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (state == S_IDLE && rb_empty && lane != '0) begin
      if (!timeout_hit) idle_cnt <= idle_cnt + 1'b1;
    end else begin
      idle_cnt <= '0;
    end
  end
`else
  // The timeout depth has no effect when the flush timer is not built.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      lane       <= '0;
      data_q     <= '0;
      keep_q     <= '0;
      out_valid  <= 1'b0;
      words_sent <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!rb_empty) begin
            state <= S_RD;
`ifdef PACKER_TIMEOUT_EN
          end else if (timeout_hit) begin
            // Flush the partial word. Unfilled lanes are already zero
            // because data/keep are cleared after every transfer.
            state     <= S_OUT;
            lane      <= '0;
            out_valid <= 1'b1;
`endif
          end
        end

        S_RD: begin
          state <= S_CAP;
        end

        S_CAP: begin
          data_q[int'(lane)*DATA_WIDTH +: DATA_WIDTH] <= rb_data;
          keep_q[lane] <= 1'b1;
          if (lane == LAST_LANE) begin
            lane      <= '0;
            out_valid <= 1'b1;
            state     <= S_OUT;
          end else begin
            lane  <= lane + 1'b1;
            state <= S_IDLE;
          end
        end

        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            data_q    <= '0;
            keep_q    <= '0;
            if (words_sent != 16'hFFFF) words_sent <= words_sent + 16'd1;
            state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
